int_to_float: RTL and testbench
===============================

# int_to_float

Iterative converter from a signed two's-complement fixed-point word to an IEEE754 single-precision float. It is the operand-preparation stage directly upstream of the float divider: DFT accumulator and sample words are integers, and this block turns them into the 32-bit float operands the divider consumes. It uses the same level handshake as the divider. A rising edge on `dataIn` starts a conversion, and a `dataOut` level marks a valid result. Normalisation is sequential, one bit per cycle.

## Interface
- `WIDTH_IN`, 32: input word width. Legal range 8..64.
- `FRAC_BITS`, 0: number of fractional bits in `din`. Legal range 0..`WIDTH_IN`-1.
- `clk` in 1: the single clock. Everything is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `dataIn` in 1: start request. Its rising edge, sampled on `clk`, launches a conversion.
- `din` in `WIDTH_IN`: signed input. It is captured on the start edge and may change afterwards.
- `dataOut` out 1: high while `result` is valid.
- `result` out 32: IEEE754 single-precision result.
- `busy` out 1: high while a conversion is in flight.

## Operation
- Start condition: a sampled `dataIn`=1 with the previously sampled value 0.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD: capture `sign`=`din` MSB and `mag`=|`din|` as a `WIDTH_IN`-bit unsigned value. −2^(W−1) maps to 2^(W−1). Load `exp` = 127 + `WIDTH_IN` − 1 − `FRAC_BITS`. Go to NORM.
  - NORM, zero magnitude: write `result`=0x00000000 (+0, never −0), set `dataOut`, go to DONE.
  - NORM, `mag[W-1]`=1: go to ROUND.
  - NORM, otherwise: `mag` <<= 1 and `exp` −= 1. Stay in NORM.
  - ROUND: take `man` = the 23 bits below `mag[W-1]`. For `WIDTH_IN` ≤ 24, zero-pad and the result is exact. Guard bit = the next lower bit. Sticky = OR of all remaining lower bits. Apply rounding (see Configuration).
  - ROUND, mantissa carry-out: `man`=0 and `exp`+1.
  - ROUND, write: `result` = {`sign`, `exp[7:0]`, `man`}, set `dataOut`, go to DONE.
  - DONE: hold `result` and `dataOut`.
- Exponent arithmetic is 10-bit. Overflow and underflow cannot occur within the legal parameter range, so there is no Inf or NaN path.
- On every start edge, `result` and `dataOut` clear to 0 and the block re-enters LOAD.
- A new start edge in any state, including mid-NORM, aborts the current conversion and restarts with the new `din`. The old result is never presented.
- `dataIn` sampled low in DONE: `dataOut` drops to 0 and `result` holds its value.
- `busy` = state ∈ {LOAD, NORM, ROUND}.

## Timing
- Reset values: `dataOut`=0, `result`=0, `busy`=0, state IDLE. The sampled-`dataIn` history register also resets to 0, so `dataIn` held high through reset starts a conversion on the first edge after `rst` deasserts.
- Let T be the edge that samples the start.
  - LOAD executes at T+1.
  - NORM occupies edges T+2 .. T+2+lz, where lz = leading zeros of `mag`.
  - ROUND executes at T+3+lz.
- `dataOut` is visible after edge T+3+lz, so the latency is lz+3 cycles.
- Latency limits: minimum 3 cycles (`mag` MSB set); maximum `WIDTH_IN`+2 cycles (`mag`=1).
- Zero input: `dataOut` is visible after edge T+2.
- `rst` overrides everything, including a start edge on the same cycle.

## Configuration
- `INT_TO_FLOAT_RNE_EN` defined: round-to-nearest-even. Increment when guard & (sticky | `man[0]`).
- Not defined: truncate toward zero. Guard and sticky are ignored, and the increment logic is removed.

## Structure
- Package `float_pkg` holds:
  - constants `FLT_BIAS`=127, `FLT_EXP_W`=8, `FLT_MAN_W`=23, `FLT_POS_ZERO`=32'h0000_0000;
  - the state enum `i2f_state_t` {IDLE, LOAD, NORM, ROUND, DONE}.
- These are shared with the divider-side logic.
- One sub-module: `in_edge_det`, a registered rising-edge detector on `dataIn` with sync-reset history. Its `level` output drives the `dataOut` drop.
- Everything else lives in one always block plus output assigns.

## Test plan
- `din`=1 with defaults -> `result`=0x3F800000, `dataOut` after 34 cycles (lz=31).
- `din`=−1 -> 0xBF800000. `din`=0x80000000 -> 0xCF000000, `dataOut` after exactly 3 cycles.
- `din`=0 -> 0x00000000 after 2 cycles. Then a new start with `din`=0x00018000 under `FRAC_BITS`=16 -> 0x3FC00000.
- `din`=16777219:
  - with RNE -> 0x4B800002;
  - without RNE -> 0x4B800001.
- `din`=0x7FFFFFFF:
  - with RNE -> 0x4F000000 (carry into exponent);
  - without RNE -> 0x4EFFFFFF.
- Abort and reset:
  - Start with `din`=1; at cycle 10 toggle `dataIn` low then high with `din`=2. Expect exactly one `dataOut` assertion, with 0x40000000.
  - Assert `rst` mid-NORM. Expect all outputs 0 on the next edge and no `dataOut` until a new start.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float constants and the converter state type, common to int_to_float
// and the divider-side logic.
package float_pkg;

  localparam int FLT_BIAS  = 127;
  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;

  localparam logic [31:0] FLT_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    ROUND,
    DONE
  } i2f_state_t;

endpackage

// File: rtl/in_edge_det.sv
// Rising-edge detector for the dataIn start request. The history flop resets
// low, so a request held high through reset fires on the first edge afterwards.
module in_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise
);

  logic hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sig;
    end
  end

  assign level = sig;
  assign rise  = sig & ~hist_q;

endmodule

// File: rtl/int_to_float.sv
// Iterative signed fixed-point to IEEE754 single converter, one normalisation
// shift per cycle. Define INT_TO_FLOAT_RNE_EN for round-to-nearest-even, else truncate.
module int_to_float
  import float_pkg::*;
#(
  parameter int WIDTH_IN  = 32,
  parameter int FRAC_BITS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dataIn,
  input  logic [WIDTH_IN-1:0] din,
  output logic                dataOut,
  output logic [31:0]         result,
  output logic                busy
);

  localparam logic [9:0] EXP_INIT = 10'(FLT_BIAS + WIDTH_IN - 1 - FRAC_BITS);

  logic                 start;
  logic                 req_level;
  i2f_state_t           state_q;
  logic [WIDTH_IN-1:0]  din_q;
  logic [WIDTH_IN-1:0]  mag_q;
  logic                 sign_q;
  logic [9:0]           exp_q;
  logic [31:0]          result_q;
  logic                 data_out_q;
  logic [FLT_MAN_W-1:0] man_trunc;
  logic [FLT_MAN_W-1:0] man_rnd;
  logic [9:0]           exp_rnd;

  in_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (dataIn),
    .level (req_level),
    .rise  (start)
  );

  // Mantissa is the 23 bits below the normalised leading one; narrow inputs zero-pad.
`ifdef INT_TO_FLOAT_RNE_EN
  logic [WIDTH_IN+22:0] mag_ext;
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [FLT_MAN_W:0]   man_sum;

  assign mag_ext    = {mag_q[WIDTH_IN-2:0], 24'd0};
  assign man_trunc  = mag_ext[WIDTH_IN+22:WIDTH_IN];
  assign guard_bit  = mag_ext[WIDTH_IN-1];
  assign sticky_bit = |mag_ext[WIDTH_IN-2:0];
  assign round_up   = guard_bit & (sticky_bit | man_trunc[0]);
  assign man_sum    = {1'b0, man_trunc} + {{FLT_MAN_W{1'b0}}, round_up};
  assign man_rnd    = man_sum[FLT_MAN_W-1:0];
  assign exp_rnd    = exp_q + {9'd0, man_sum[FLT_MAN_W]};
`else
  logic [WIDTH_IN+21:0] mag_ext;

  assign mag_ext   = {mag_q[WIDTH_IN-2:0], 23'd0};
  assign man_trunc = FLT_MAN_W'(mag_ext >> (WIDTH_IN - 1));
  assign man_rnd   = man_trunc;
  assign exp_rnd   = exp_q;
`endif

  // A start edge from any state discards the conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      din_q      <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      result_q   <= FLT_POS_ZERO;
      data_out_q <= 1'b0;
    end else if (start) begin
      state_q    <= LOAD;
      din_q      <= din;
      result_q   <= FLT_POS_ZERO;
      data_out_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          sign_q  <= din_q[WIDTH_IN-1];
          mag_q   <= din_q[WIDTH_IN-1] ? -din_q : din_q;
          exp_q   <= EXP_INIT;
          state_q <= NORM;
        end
        NORM: begin
          if (mag_q == '0) begin
            result_q   <= FLT_POS_ZERO;
            data_out_q <= 1'b1;
            state_q    <= DONE;
          end else if (mag_q[WIDTH_IN-1]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 10'd1;
          end
        end
        ROUND: begin
          result_q   <= {sign_q, FLT_EXP_W'(exp_rnd), man_rnd};
          data_out_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (!req_level) begin
            data_out_q <= 1'b0;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign dataOut = data_out_q;
  assign result  = result_q;
  assign busy    = (state_q == LOAD) || (state_q == NORM) || (state_q == ROUND);

endmodule

// File: tb/tb_int_to_float.sv
// Randomised self-checking bench for int_to_float: three parameterisations share
// one stimulus stream and are compared every cycle against an arithmetic model.
module tb_int_to_float;

`ifdef INT_TO_FLOAT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dataIn;
  logic [31:0] din;

  logic        dOut0, dOut1, dOut2;
  logic [31:0] res0, res1, res2;
  logic        bsy0, bsy1, bsy2;

  int          tests = 0;
  int          fails = 0;
  int          edgeCnt = 0;
  int          startEdge = 0;
  bit          track = 1'b0;
  int          riseCnt = 0;
  logic        prevDout = 1'b0;
  logic [31:0] expRes [3];
  int          expLat [3];

  int_to_float #(.WIDTH_IN(32), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .din(din),
    .dataOut(dOut0), .result(res0), .busy(bsy0)
  );

  int_to_float #(.WIDTH_IN(32), .FRAC_BITS(16)) dut1 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .din(din),
    .dataOut(dOut1), .result(res1), .busy(bsy1)
  );

  int_to_float #(.WIDTH_IN(12), .FRAC_BITS(3)) dut2 (
    .clk(clk), .rst(rst), .dataIn(dataIn), .din(din[11:0]),
    .dataOut(dOut2), .result(res2), .busy(bsy2)
  );

  always #5 clk = ~clk;

  // Reference: real value v / 2^f rounded to single precision.
  function automatic logic [31:0] refFloat(input longint v, input int f);
    bit                s;
    longint unsigned   m;
    longint unsigned   man;
    longint unsigned   rem;
    longint unsigned   half;
    int                p;
    int                sh;
    int                ex;
    s = (v < 0);
    m = s ? 64'(-v) : 64'(v);
    if (m == 0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    ex = 127 + p - f;
    if (p <= 23) begin
      man = m << (23 - p);
    end else begin
      sh   = p - 23;
      man  = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (RNE && ((rem > half) || (rem == half && man[0]))) man = man + 64'd1;
      if (man == (64'd1 << 24)) begin
        man = man >> 1;
        ex  = ex + 1;
      end
    end
    return {s, 8'(ex), man[22:0]};
  endfunction

  function automatic int refLat(input longint v, input int w);
    longint unsigned m;
    int              p;
    m = (v < 0) ? 64'(-v) : 64'(v);
    if (m == 0) return 2;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return (w - 1 - p) + 3;
  endfunction

  task automatic checkPin(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input int idx, input int k, input logic dO,
                             input logic [31:0] r, input logic b);
    logic        expDo;
    logic [31:0] expR;
    expDo = (k >= expLat[idx]);
    expR  = expDo ? expRes[idx] : 32'h0;
    tests++;
    if (dO !== expDo || b !== !expDo || r !== expR) begin
      fails++;
      $display("[TB] FAIL inst%0d edge+%0d: got dataOut=%0b busy=%0b result=%h, want dataOut=%0b busy=%0b result=%h",
               idx, k, dO, b, r, expDo, !expDo, expR);
    end
  endtask

  task automatic checkIdle(input string name);
    checkPin({name, " inst0"}, {30'd0, dOut0, bsy0, res0}, 64'd0);
    checkPin({name, " inst1"}, {30'd0, dOut1, bsy1, res1}, 64'd0);
    checkPin({name, " inst2"}, {30'd0, dOut2, bsy2, res2}, 64'd0);
  endtask

  // Single compare process: every edge of a tracked conversion is checked.
  always @(posedge clk) begin
    #1;
    edgeCnt++;
    if (dOut0 === 1'b1 && prevDout !== 1'b1) riseCnt++;
    prevDout = dOut0;
    if (track && edgeCnt >= startEdge) begin
      checkOutput(0, edgeCnt - startEdge, dOut0, res0, bsy0);
      checkOutput(1, edgeCnt - startEdge, dOut1, res1, bsy1);
      checkOutput(2, edgeCnt - startEdge, dOut2, res2, bsy2);
    end
  end

  task automatic armModel();
    longint v32;
    longint v12;
    v32 = longint'($signed(din));
    v12 = longint'($signed(din[11:0]));
    expRes[0] = refFloat(v32, 0);
    expLat[0] = refLat(v32, 32);
    expRes[1] = refFloat(v32, 16);
    expLat[1] = refLat(v32, 32);
    expRes[2] = refFloat(v12, 3);
    expLat[2] = refLat(v12, 12);
    startEdge = edgeCnt + 1;
    track     = 1'b1;
  endtask

  task automatic finishConv();
    int m;
    m = expLat[0];
    if (expLat[2] > m) m = expLat[2];
    repeat (m + 1) @(negedge clk);
    track  = 1'b0;
    dataIn = 1'b0;
    @(negedge clk);
    checkPin("hold inst0", {31'd0, dOut0, res0}, {32'd0, expRes[0]});
    checkPin("hold inst1", {31'd0, dOut1, res1}, {32'd0, expRes[1]});
    checkPin("hold inst2", {31'd0, dOut2, res2}, {32'd0, expRes[2]});
  endtask

  task automatic applyStimulus(input logic [31:0] val);
    dataIn = 1'b0;
    @(negedge clk);
    din = val;
    armModel();
    dataIn = 1'b1;
    finishConv();
  endtask

  initial begin
    int r0;
    logic [31:0] r;
    rst    = 1'b1;
    dataIn = 1'b0;
    din    = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset state");
    rst = 1'b0;

    checkPin("model 1",          {32'd0, refFloat(1, 0)},              {32'd0, 32'h3F80_0000});
    checkPin("model -1",         {32'd0, refFloat(-1, 0)},             {32'd0, 32'hBF80_0000});
    checkPin("model min int",    {32'd0, refFloat(-64'sd2147483648, 0)}, {32'd0, 32'hCF00_0000});
    checkPin("model 1.5 q16",    {32'd0, refFloat(64'h18000, 16)},     {32'd0, 32'h3FC0_0000});
    checkPin("model 16777219",   {32'd0, refFloat(16777219, 0)},
             {32'd0, RNE ? 32'h4B80_0002 : 32'h4B80_0001});
    checkPin("model 7fffffff",   {32'd0, refFloat(64'h7FFF_FFFF, 0)},
             {32'd0, RNE ? 32'h4F00_0000 : 32'h4EFF_FFFF});
    checkPin("latency 1",        64'(refLat(1, 32)), 64'd34);
    checkPin("latency min int",  64'(refLat(-64'sd2147483648, 32)), 64'd3);
    checkPin("latency zero",     64'(refLat(0, 32)), 64'd2);

    applyStimulus(32'h0000_0001);
    applyStimulus(32'hFFFF_FFFF);
    applyStimulus(32'h8000_0000);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0001_8000);
    applyStimulus(32'd16777219);
    applyStimulus(32'h7FFF_FFFF);
    applyStimulus(32'h0000_0800);

    // Abort: restart mid-NORM must present only the second result.
    r0 = riseCnt;
    @(negedge clk);
    din    = 32'h0000_0001;
    dataIn = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(32'h0000_0002);
    checkPin("abort result", {32'd0, expRes[0]}, {32'd0, 32'h4000_0000});
    checkPin("abort dataOut count", 64'(riseCnt - r0), 64'd1);

    // Reset mid-NORM with the request withdrawn.
    @(negedge clk);
    din    = 32'h0000_0001;
    dataIn = 1'b1;
    repeat (8) @(negedge clk);
    rst    = 1'b1;
    dataIn = 1'b0;
    @(posedge clk);
    #2;
    checkIdle("reset mid-NORM");
    @(negedge clk);
    rst = 1'b0;
    r0  = riseCnt;
    repeat (40) @(negedge clk);
    checkPin("no dataOut after reset", 64'(riseCnt - r0), 64'd0);

    // Request held high through reset starts right after release.
    @(negedge clk);
    din    = 32'hFFFF_F000;
    dataIn = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    armModel();
    finishConv();

    repeat (150) begin
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      applyStimulus(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
